// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle shift-add multiplier behind MIPS mult/multu.
// Takes one operand pair per accepted Start and forms one partial product
// per clock for WIDTH clocks. A fix-up cycle then negates the product for
// signed operations with a negative result. HI/LO are written at completion,
// or directly by mthi/mtlo while the unit is idle.
//
// Ports:
//   CLK         system clock, rising edge
//   ClearN      asynchronous active-low reset
//   Start       request a multiply (accepted in IDLE or DONE only)
//   Signed      1 = two's complement operands, 0 = unsigned
//   A, B        operands, sampled on the accepting edge
//   HiWe, LoWe  direct writes of WData into High/Low, honoured when not Busy
//   WData       data for HiWe/LoWe
//   Busy        high while iterating (RUN) and during sign fix-up (FIX)
//   Done        high for the single cycle in DONE; High/Low valid then
//   High, Low   registered upper/lower product halves
module mul_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             ClearN,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiWe,
  input  logic             LoWe,
  input  logic [WIDTH-1:0] WData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] High,
  output logic [WIDTH-1:0] Low
);

  localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   high_q, high_d;
  logic [WIDTH-1:0]   low_q, low_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   addend;
  logic [PROD_W-1:0]  product;
  logic [PROD_W-1:0]  result;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // State and datapath registers
  always_ff @(posedge CLK or negedge ClearN) begin
    if (!ClearN) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      high_q   <= '0;
      low_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      high_q   <= high_d;
      low_q    <= low_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state, iteration step, fix-up and HI/LO write logic
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    high_d   = high_q;
    low_d    = low_q;

    // Magnitudes; the most negative value maps onto itself as an unsigned magnitude
    a_mag   = (Signed && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
    b_mag   = (Signed && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;

    addend  = mplier_q[0] ? mcand_q : '0;
    sum     = {1'b0, acc_q} + {1'b0, addend};
    product = {acc_q, mplier_q};
    result  = neg_q ? (~product + PROD_W'(1)) : product;

    // mthi/mtlo only while not busy; a write may coincide with an accepted Start
    if (!busy_q) begin
      if (HiWe) high_d = WData;
      if (LoWe) low_d  = WData;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d  = S_RUN;
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        // Add then shift {carry, acc, multiplier} right by one
        acc_d    = sum[WIDTH:1];
        mplier_d = WIDTH'({sum[0], mplier_q} >> 1);
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        high_d  = result[PROD_W-1:WIDTH];
        low_d   = result[WIDTH-1:0];
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign High = high_q;
  assign Low  = low_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: the driver pushes hand-computed
// {High, Low} results as it issues operations; a monitor pops and compares
// on every cycle in which Done is high.
module tb_mul_sequencer;

  localparam int unsigned WIDTH = 32;

  logic             CLK;
  logic             ClearN;
  logic             Start;
  logic             Signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             HiWe;
  logic             LoWe;
  logic [WIDTH-1:0] WData;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] High;
  logic [WIDTH-1:0] Low;

  int checks;
  int errors;
  int done_cnt;
  logic [63:0] exp_q[$];

  mul_sequencer #(.WIDTH(WIDTH)) dut (
    .CLK    (CLK),
    .ClearN (ClearN),
    .Start  (Start),
    .Signed (Signed),
    .A      (A),
    .B      (B),
    .HiWe   (HiWe),
    .LoWe   (LoWe),
    .WData  (WData),
    .Busy   (Busy),
    .Done   (Done),
    .High   (High),
    .Low    (Low)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every Done cycle must match the oldest outstanding expectation
  initial begin
    logic [63:0] e;
    done_cnt = 0;
    forever begin
      @(negedge CLK);
      if (Done === 1'b1) begin
        done_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got Done=1 with no operation outstanding at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("result_hi_lo", {High, Low}, e);
        end
      end
    end
  end

  // Pulse Start for one accepted edge; operands are scrambled right after
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic push, input logic [31:0] eh, input logic [31:0] el);
    @(negedge CLK);
    Start = 1'b1; A = a; B = b; Signed = s;
    if (push) exp_q.push_back({eh, el});
    @(negedge CLK);
    Start = 1'b0; A = $urandom; B = $urandom; Signed = ~s;
    chk("busy_after_accept", {63'd0, Busy}, 64'd1);
  endtask

  // Bounded wait for Done; checks latency in negedges, Busy low, one-cycle Done
  task automatic wait_done(input string name, input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (Done !== 1'b1 && n < 200);
    chk(name, 64'(n), 64'(exp_n));
    chk("busy_low_at_done", {63'd0, Busy}, 64'd0);
    @(negedge CLK);
    chk("done_single_cycle", {63'd0, Done}, 64'd0);
  endtask

  initial begin
    int saved;
    checks = 0; errors = 0;
    ClearN = 1'b0; Start = 1'b0; Signed = 1'b0; A = '0; B = '0;
    HiWe = 1'b0; LoWe = 1'b0; WData = '0;
    repeat (2) @(negedge CLK);
    chk("reset_busy", {63'd0, Busy}, 64'd0);
    chk("reset_done", {63'd0, Done}, 64'd0);
    chk("reset_hi_lo", {High, Low}, 64'd0);
    ClearN = 1'b1;
    repeat (2) @(negedge CLK);

    // Basic and corner products
    issue(32'h0000007F, 32'h00000070, 1'b0, 1'b1, 32'h00000000, 32'h00003790);
    wait_done("latency_basic", 33);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFE, 32'h00000001);
    wait_done("latency", 33);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, 32'h00000001);
    wait_done("latency", 33);
    issue(32'h80000000, 32'h80000000, 1'b1, 1'b1, 32'h40000000, 32'h00000000);
    wait_done("latency", 33);
    issue(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("latency", 33);
    issue(32'h00000000, 32'h80000000, 1'b1, 1'b1, 32'h00000000, 32'h00000000);
    wait_done("latency", 33);
    issue(32'hFFFFFFFD, 32'h00000005, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1);
    wait_done("latency", 33);
    issue(32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF2);
    wait_done("latency", 33);
    issue(32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h40000000, 32'h00000000);
    wait_done("latency", 33);

    // Start pulsed at E5 while busy is ignored
    issue(32'h12345678, 32'h00000100, 1'b0, 1'b1, 32'h00000012, 32'h34567800);
    repeat (4) @(negedge CLK);
    Start = 1'b1; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; Signed = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    wait_done("latency_ignored_start", 28);
    saved = done_cnt;
    repeat (40) @(negedge CLK);
    chk("no_extra_done", 64'(done_cnt), 64'(saved));

    // Back-to-back with Start held through DONE
    @(negedge CLK);
    Start = 1'b1; A = 32'h00010000; B = 32'h00010000; Signed = 1'b0;
    exp_q.push_back({32'h00000001, 32'h00000000});
    exp_q.push_back({32'h00000000, 32'hFFFE0001});
    @(negedge CLK);
    A = 32'h0000FFFF; B = 32'h0000FFFF;
    chk("b2b_busy_first", {63'd0, Busy}, 64'd1);
    begin
      int n;
      n = 0;
      do begin
        @(negedge CLK);
        n++;
      end while (Done !== 1'b1 && n < 200);
      chk("b2b_first_latency", 64'(n), 64'd33);
    end
    @(negedge CLK);
    Start = 1'b0;
    chk("b2b_busy_second", {63'd0, Busy}, 64'd1);
    wait_done("b2b_second_after_first_minus1", 33);

    // Direct HI/LO writes while idle
    @(negedge CLK);
    HiWe = 1'b1; WData = 32'hDEADBEEF;
    @(negedge CLK);
    HiWe = 1'b0;
    chk("mthi_idle", {High, Low}, {32'hDEADBEEF, 32'hFFFE0001});
    LoWe = 1'b1; WData = 32'hCAFEF00D;
    @(negedge CLK);
    LoWe = 1'b0;
    chk("mtlo_idle", {High, Low}, {32'hDEADBEEF, 32'hCAFEF00D});

    // Writes while busy are dropped
    issue(32'h00000003, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 32'h0000000F);
    repeat (2) @(negedge CLK);
    HiWe = 1'b1; LoWe = 1'b1; WData = 32'h11111111;
    @(negedge CLK);
    HiWe = 1'b0; LoWe = 1'b0;
    @(negedge CLK);
    chk("write_while_busy", {High, Low}, {32'hDEADBEEF, 32'hCAFEF00D});
    wait_done("latency_write_busy", 29);

    // Start and mthi on the same accepted edge
    @(negedge CLK);
    Start = 1'b1; A = 32'h00000002; B = 32'h00000003; Signed = 1'b0;
    HiWe = 1'b1; WData = 32'hABCDABCD;
    exp_q.push_back({32'h00000000, 32'h00000006});
    @(negedge CLK);
    Start = 1'b0; HiWe = 1'b0;
    chk("start_plus_mthi", {High, Low}, {32'hABCDABCD, 32'h0000000F});
    wait_done("latency_start_plus_mthi", 33);

    // Reset at E10 aborts the run
    issue(32'h00001234, 32'h00000010, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (9) @(negedge CLK);
    saved = done_cnt;
    ClearN = 1'b0;
    #1;
    chk("abort_busy", {63'd0, Busy}, 64'd0);
    chk("abort_done", {63'd0, Done}, 64'd0);
    chk("abort_hi_lo", {High, Low}, 64'd0);
    @(negedge CLK);
    ClearN = 1'b1;
    repeat (40) @(negedge CLK);
    chk("abort_no_done", 64'(done_cnt), 64'(saved));

    issue(32'h00001234, 32'h00000010, 1'b0, 1'b1, 32'h00000000, 32'h00012340);
    wait_done("latency_after_reset", 33);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle shift-add multiplier with its own sequencing FSM and HI/LO result registers, the multiply resource behind the MIPS `mult` and `multu` instructions. It accepts one operand pair per Start, iterates one partial product per clock, and applies a sign fix-up for signed operations. It presents the 2·WIDTH-bit product on High/Low with a Busy/Done handshake toward the CPU control unit.

## Interface
- WIDTH, 32, operand width; the product is 2·WIDTH bits and the iteration count equals WIDTH.
- CLK  input  1  system clock; all state changes on the rising edge.
- ClearN  input  1  reset, asynchronous, active-low.
- Start  input  1  request a multiply; sampled only in IDLE or DONE.
- Signed  input  1  1 = `mult` (two's complement), 0 = `multu`; sampled with Start.
- A, B  input  WIDTH  operands; sampled with Start, ignored otherwise.
- HiWe, LoWe  input  1  direct write to High/Low (`mthi`/`mtlo`); honoured only when Busy=0.
- WData  input  WIDTH  data for HiWe/LoWe.
- Busy  output  1  high in RUN and FIX.
- Done  output  1  high for exactly the one cycle spent in DONE.
- High, Low  output  WIDTH  registered upper and lower product halves.

## Operation
- States and transitions:
  - IDLE → RUN on Start.
  - RUN → RUN while count < WIDTH−1; otherwise RUN → FIX.
  - FIX → DONE.
  - DONE → RUN on Start; otherwise DONE → IDLE.
- Operand capture, on the edge that accepts Start:
  - With Signed=1, latch the magnitudes |A| and |B| as WIDTH-bit unsigned values. 0x80000000 gives magnitude 0x80000000, which is legal.
  - Also latch Neg = A[WIDTH−1] ^ B[WIDTH−1].
  - With Signed=0, latch A and B unchanged and set Neg=0.
  - Clear the WIDTH+1-bit accumulator and the iteration counter.
- RUN, each cycle:
  - If multiplier LSB = 1, set {carry, acc} = acc + multiplicand.
  - Shift {carry, acc, multiplier} right one bit.
  - count increments.
  - After WIDTH iterations, {acc, multiplier} holds the unsigned 2·WIDTH-bit product.
- FIX: the result is the product, or its 2·WIDTH-bit two's complement when Neg=1. High/Low load the result on the FIX→DONE edge.
- High/Low change only on:
  - the FIX→DONE edge;
  - HiWe/LoWe while Busy=0;
  - reset.
- HiWe/LoWe while Busy=1 are ignored, not queued.
- Start while Busy=1 is ignored, and the operation in flight is unaffected.
- HiWe/LoWe and Start in the same accepted cycle: both take effect. The write lands now; the product overwrites High/Low at completion.
- A, B and Signed may change freely after the accepting edge.

## Timing
- Reset, with ClearN low, asynchronously forces:
  - state = IDLE;
  - Busy = 0 and Done = 0;
  - High = 0 and Low = 0;
  - counter and accumulator = 0.
- ClearN asserted mid-RUN or mid-FIX aborts the operation. No partial result reaches High/Low.
- Edge numbering: let E0 be the edge that accepts Start.
  - RUN iterations occupy edges E1..E32 (for WIDTH=32).
  - FIX is evaluated at E33, when High/Low update.
  - Done = 1 in the cycle between E33 and E34.
  - Busy = 1 from after E0 until E33: 33 cycles.
- Latency from the accepting edge to Done high is WIDTH+1 edges. The result on High/Low is valid in the same cycle Done is high.
- Back-to-back operation: Start held high in DONE is accepted at E34, giving one product every WIDTH+2 cycles.
- Done never asserts without a preceding accepted Start. It is never high for two consecutive cycles unless a new operation completes.

## Test plan
- Unsigned: A=0x0000007F, B=0x00000070, Signed=0, Start for one cycle.
  - Busy rises after E0.
  - Done is high only in the cycle after E33.
  - High=0x00000000, Low=0x00003790.
- Width corners:
  - Unsigned 0xFFFFFFFF×0xFFFFFFFF → High=0xFFFFFFFE, Low=0x00000001.
  - Signed, same operands (−1×−1) → High=0x00000000, Low=0x00000001.
- Signed extremes:
  - 0x80000000×0x80000000 → High=0x40000000, Low=0x00000000.
  - 0xFFFFFFFF×0x00000001 → High=0xFFFFFFFF, Low=0xFFFFFFFF.
  - 0x00000000×0x80000000 → High=Low=0 (Neg=1 with a zero product stays 0).
- Handshake:
  - Start pulsed at E5 of a run is ignored: a single Done, and the result matches the first operands.
  - A/B changed during RUN do not alter the result.
  - Start held high through DONE starts a second operation at E34, and the second Done follows WIDTH+2 cycles after the first.
- HI/LO writes:
  - In IDLE, HiWe with WData=0xDEADBEEF → High=0xDEADBEEF on the next edge, Low unchanged.
  - The same write while Busy=1 → High unchanged.
- Reset mid-run: ClearN low for one cycle at E10.
  - Busy, Done, High and Low go to 0 immediately.
  - No Done follows.
  - A fresh Start afterwards completes normally.
